ula_datapath: RTL and testbench

- Small accumulator-style datapath: one WIDTH-bit register fed by a 2:1 mux (external data or ALU feedback).
- Register output is steered by a 1:2 demux to ALU operand A or operand B; the unselected operand is forced to 0.
- The combinational ALU produces resultado and carry_out.
- Used as the basic execution slice for the course processor exercises.

---
 rtl/ula_datapath_if.sv | 33 +++
 rtl/ula_datapath.sv | 85 ++++++++
 tb/tb_ula_datapath.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ula_datapath_if.sv
// Bus bundle for ula_datapath: data/control inputs and the combinational ALU outputs.
// With ULA_DATAPATH_ZERO_FLAG_EN defined, the bundle also carries zero_flag.
interface ula_datapath_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] dados;
  logic             sel21;
  logic             sel12;
  logic [2:0]       operacao;
  logic [WIDTH-1:0] resultado;
  logic             carry_out;
`ifdef ULA_DATAPATH_ZERO_FLAG_EN
  logic             zero_flag;

  modport master (
    output dados, sel21, sel12, operacao,
    input  resultado, carry_out, zero_flag
  );
  modport slave (
    input  dados, sel21, sel12, operacao,
    output resultado, carry_out, zero_flag
  );
`else
  modport master (
    output dados, sel21, sel12, operacao,
    input  resultado, carry_out
  );
  modport slave (
    input  dados, sel21, sel12, operacao,
    output resultado, carry_out
  );
`endif
endinterface

// File: rtl/ula_datapath.sv
// Accumulator slice: register <- mux(dados, resultado), demux to ALU A/B, combinational ALU.
// Optional ULA_DATAPATH_ZERO_FLAG_EN adds zero_flag (resultado == 0).
module ula_datapath #(
  parameter int unsigned WIDTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  ula_datapath_if.slave  bus
);

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_INC = 3'b110,
    OP_DEC = 3'b111
  } op_t;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mux_out;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [WIDTH:0]   wide;
  op_t              op;

  always_comb mux_out = bus.sel21 ? res : bus.dados;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) acc <= '0;
    else        acc <= mux_out;
  end

  always_comb begin
    op_a = bus.sel12 ? '0  : acc;
    op_b = bus.sel12 ? acc : '0;
  end

  // Arithmetic runs one bit wider; for SUB/DEC the extra bit is a borrow, so carry is its inverse.
  always_comb begin
    op    = op_t'(bus.operacao);
    wide  = '0;
    carry = 1'b0;
    case (op)
      OP_ADD: begin
        wide  = {1'b0, op_a} + {1'b0, op_b};
        carry = wide[WIDTH];
      end
      OP_SUB: begin
        wide  = {1'b0, op_a} - {1'b0, op_b};
        carry = ~wide[WIDTH];
      end
      OP_AND: wide = {1'b0, op_a & op_b};
      OP_OR:  wide = {1'b0, op_a | op_b};
      OP_XOR: wide = {1'b0, op_a ^ op_b};
      OP_NOT: wide = {1'b0, ~op_a};
      OP_INC: begin
        wide  = {1'b0, op_a} + ONE;
        carry = wide[WIDTH];
      end
      OP_DEC: begin
        wide  = {1'b0, op_a} - ONE;
        carry = ~wide[WIDTH];
      end
      default: begin
        wide  = '0;
        carry = 1'b0;
      end
    endcase
    res = wide[WIDTH-1:0];
  end

  assign bus.resultado = res;
  assign bus.carry_out = carry;
`ifdef ULA_DATAPATH_ZERO_FLAG_EN
  assign bus.zero_flag = (res == '0);
`endif

endmodule

// File: tb/tb_ula_datapath.sv
// Directed + randomized bench for ula_datapath against an arithmetic reference model.
module tb_ula_datapath;

  localparam int unsigned W   = 4;
  localparam int unsigned MOD = 1 << W;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int unsigned mreg;

  ula_datapath_if #(.WIDTH(W)) bus ();

  ula_datapath #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  function automatic void model(input int unsigned op, input int unsigned a,
                                input int unsigned b, output int unsigned r,
                                output bit c);
    r = 0;
    c = 1'b0;
    case (op)
      0: begin r = (a + b) % MOD; c = (a + b) >= MOD; end
      1: begin r = (a + MOD - b) % MOD; c = (a >= b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (MOD - 1) - a;
      6: begin r = (a + 1) % MOD; c = (a == MOD - 1); end
      default: begin r = (a + MOD - 1) % MOD; c = (a != 0); end
    endcase
  endfunction

  function automatic void expected(output int unsigned r, output bit c);
    int unsigned a, b;
    a = bus.sel12 ? 0 : mreg;
    b = bus.sel12 ? mreg : 0;
    model(int'(bus.operacao), a, b, r, c);
  endfunction

  task automatic check(input string tag);
    int unsigned er;
    bit ec;
    logic [W-1:0] exp_r;
    #1;
    expected(er, ec);
    exp_r = er[W-1:0];
    checks++;
    assert (bus.resultado === exp_r) else begin
      failures++;
      $error("FAIL %s resultado=%0h expected=%0h", tag, bus.resultado, exp_r);
    end
    checks++;
    assert (bus.carry_out === ec) else begin
      failures++;
      $error("FAIL %s carry_out=%0b expected=%0b", tag, bus.carry_out, ec);
    end
`ifdef ULA_DATAPATH_ZERO_FLAG_EN
    checks++;
    assert (bus.zero_flag === (er == 0)) else begin
      failures++;
      $error("FAIL %s zero_flag=%0b expected=%0b", tag, bus.zero_flag, (er == 0));
    end
`endif
  endtask

  task automatic tick();
    int unsigned er, nxt;
    bit ec;
    expected(er, ec);
    nxt = !reset ? 0 : (bus.sel21 ? er : int'(bus.dados));
    @(posedge clk);
    mreg = nxt;
    #1;
  endtask

  task automatic load(input int unsigned v);
    bus.dados = v[W-1:0];
    bus.sel21 = 1'b0;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    mreg     = 0;
    bus.dados    = '0;
    bus.sel21    = 1'b0;
    bus.sel12    = 1'b0;
    bus.operacao = 3'b000;
    reset = 1'b1;
    #1 reset = 1'b0;
    mreg = 0;

    // Reset: every opcode on zero operands, both demux settings
    for (int op = 0; op < 8; op++) begin
      bus.operacao = op[2:0];
      check("reset_op");
    end
    bus.sel12 = 1'b1;
    bus.operacao = 3'b001;
    check("reset_sub_b");
    bus.sel12 = 1'b0;
    bus.operacao = 3'b000;
    tick();
    check("reset_held_edge");
    reset = 1'b1;

    // Load and demux
    load(5);
    check("load_a");
    bus.sel12 = 1'b1;
    check("demux_b_add");

    // Feedback and INC
    bus.sel21 = 1'b1;
    tick();
    check("feedback_hold5");
    bus.sel12 = 1'b0;
    bus.operacao = 3'b110;
    check("inc_5");
    load(15);
    check("inc_wrap");

    // Logic ops and SUB
    load(3);
    bus.sel12 = 1'b1;
    for (int op = 1; op < 5; op++) begin
      bus.operacao = op[2:0];
      check("logic_sub_b");
    end
    bus.sel12 = 1'b0;
    bus.operacao = 3'b001;
    check("sub_a_minus_0");

    // ADD feedback with B=0 keeps 0xF; DEC at 0 borrows
    load(15);
    bus.operacao = 3'b000;
    bus.sel21 = 1'b1;
    tick();
    tick();
    check("add_feedback_f");
    load(0);
    bus.operacao = 3'b111;
    check("dec_zero");
    bus.sel21 = 1'b1;
    tick();
    check("dec_feedback");

    // Async reset between edges
    load(10);
    bus.operacao = 3'b011;
    check("pre_async_or");
    #20 reset = 1'b0;
    mreg = 0;
    check("async_or");
    bus.operacao = 3'b010;
    check("async_and");
    bus.sel21 = 1'b0;
    bus.dados = 4'h7;
    tick();
    check("reset_blocks_load");
    #20 reset = 1'b1;
    check("released_no_edge");
    tick();
    bus.operacao = 3'b000;
    check("load_after_release");

    // Randomized traffic with occasional mid-cycle reset pulses
    for (int i = 0; i < 300; i++) begin
      bus.dados    = W'($urandom_range(MOD - 1));
      bus.sel21    = 1'($urandom_range(1));
      bus.sel12    = 1'($urandom_range(1));
      bus.operacao = 3'($urandom_range(7));
      tick();
      check("rand_post_edge");
      bus.operacao = 3'($urandom_range(7));
      bus.sel12    = 1'($urandom_range(1));
      check("rand_ctrl_change");
      if ($urandom_range(15) == 0) begin
        #10 reset = 1'b0;
        mreg = 0;
        check("rand_async_reset");
        #10 reset = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
